vote_capture: RTL and testbench

- Upstream front end of the 9-voter voting system; conditions the raw voter switches and the start/clear buttons.
- Enforces a timed voting window and presents a frozen, stable 9-bit ballot to the tally/display stage on its vote[8:0] input.
- Runs on the same board clock as the tally stage.

---
 rtl/vote_pkg.sv | 17 +
 rtl/debounce_ch.sv | 44 ++++
 rtl/vote_capture.sv | 151 +++++++++++++++
 tb/tb_vote_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared definitions for the voting system: voter count and the capture-stage
// state encoding, which the display stage also decodes to show status.
package vote_pkg;

   localparam int N_VOTERS_DEF = 9;

   localparam logic [1:0] ENC_IDLE   = 2'b00;
   localparam logic [1:0] ENC_OPEN   = 2'b01;
   localparam logic [1:0] ENC_CLOSED = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = ENC_IDLE,
      ST_OPEN   = ENC_OPEN,
      ST_CLOSED = ENC_CLOSED
   } state_t;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: 2-FF synchroniser followed by a counter debouncer that
// accepts a new level only after DB_CNT consecutive cycles of disagreement.
module debounce_ch #(
   parameter int DB_CNT = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 != level) begin
         if (cnt == CW'(DB_CNT - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/vote_capture.sv
// Voting front end: conditions switches and buttons, runs the timed voting
// window and presents a frozen ballot to the tally stage.
//
// state     | meaning
// ST_IDLE   | no window, ballot cleared
// ST_OPEN   | window running, ballot tracks switches, countdown active
// ST_CLOSED | ballot frozen and valid until clear
module vote_capture
   import vote_pkg::*;
#(
   parameter int N_VOTERS    = N_VOTERS_DEF,
   parameter int DB_CNT      = 500000,
   parameter int TICK_CYCLES = 50000000,
   parameter int WINDOW_S    = 30
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_VOTERS-1:0] sw_raw,
   input  logic                start_btn,
   input  logic                clear_btn,
   output logic [N_VOTERS-1:0] vote,
   output logic                vote_valid,
   output logic [1:0]          state,
   output logic [6:0]          remaining_s
);

   localparam int NCH = N_VOTERS + 2;
   localparam int TW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [NCH-1:0]      raw_all;
   logic [NCH-1:0]      lvl_all;
   logic [N_VOTERS-1:0] sw_lvl;
   logic                start_lvl;
   logic                clear_lvl;
   logic [1:0]          btn_d;
   logic                start_p;
   logic                clear_p;

   assign raw_all = {clear_btn, start_btn, sw_raw};

   for (genvar i = 0; i < NCH; i++) begin : g_db
      debounce_ch #(.DB_CNT(DB_CNT)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_all[i]),
         .level (lvl_all[i])
      );
   end

   assign sw_lvl    = lvl_all[N_VOTERS-1:0];
   assign start_lvl = lvl_all[N_VOTERS];
   assign clear_lvl = lvl_all[N_VOTERS+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) btn_d <= 2'b00;
      else        btn_d <= {clear_lvl, start_lvl};
   end

   assign start_p = start_lvl & ~btn_d[0];
   assign clear_p = clear_lvl & ~btn_d[1];

   state_t              state_q, state_n;
   logic [6:0]          rem_q, rem_n;
   logic [TW-1:0]       tick_q, tick_n;
   logic [N_VOTERS-1:0] vote_q, vote_n;
   logic                valid_q, valid_n;
   logic                tick_wrap;
   logic                timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         tick_q  <= '0;
         vote_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         rem_q   <= rem_n;
         tick_q  <= tick_n;
         vote_q  <= vote_n;
         valid_q <= valid_n;
      end
   end

   assign tick_wrap = (tick_q == TW'(TICK_CYCLES - 1));
   // A window already at zero closes at once rather than waiting for a tick.
   assign timeout   = (rem_q == 7'd0) || (tick_wrap && rem_q == 7'd1);

   always_comb begin
      state_n = state_q;
      rem_n   = rem_q;
      tick_n  = tick_q;
      vote_n  = vote_q;
      valid_n = valid_q;
      case (state_q)
         ST_IDLE: begin
            vote_n  = '0;
            valid_n = 1'b0;
            rem_n   = '0;
            tick_n  = '0;
            if (start_p) begin
               state_n = ST_OPEN;
               rem_n   = 7'(WINDOW_S);
            end
         end
         ST_OPEN: begin
            vote_n  = sw_lvl;
            valid_n = 1'b0;
            tick_n  = tick_wrap ? '0 : tick_q + 1'b1;
            if (tick_wrap && rem_q != 7'd0) rem_n = rem_q - 7'd1;
            if (clear_p) begin
               state_n = ST_IDLE;
               vote_n  = '0;
               rem_n   = '0;
               tick_n  = '0;
            end else if (timeout) begin
               state_n = ST_CLOSED;
               rem_n   = '0;
               valid_n = 1'b1;
            end else if (start_p) begin
               state_n = ST_CLOSED;
               valid_n = 1'b1;
            end
         end
         ST_CLOSED: begin
            valid_n = 1'b1;
            if (clear_p) begin
               state_n = ST_IDLE;
               vote_n  = '0;
               valid_n = 1'b0;
               rem_n   = '0;
               tick_n  = '0;
            end
         end
         default: begin
            state_n = ST_IDLE;
            vote_n  = '0;
            valid_n = 1'b0;
            rem_n   = '0;
            tick_n  = '0;
         end
      endcase
   end

   assign vote        = vote_q;
   assign vote_valid  = valid_q;
   assign state       = state_q;
   assign remaining_s = rem_q;

endmodule

// File: tb/tb_vote_capture.sv
// Self-checking bench for vote_capture with short debounce/tick constants;
// finalised ballots are checked against a queue of expected votes.
module tb_vote_capture;
   import vote_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] sw_raw;
   logic       start_btn;
   logic       clear_btn;
   logic [8:0] vote;
   logic       vote_valid;
   logic [1:0] state;
   logic [6:0] remaining_s;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] exp_q[$];
   logic [8:0] sb_exp;
   logic       valid_prev = 1'b0;

   typedef struct {
      logic [8:0] sw;
      logic [8:0] exp_vote;
      logic [6:0] exp_rem;
      logic [1:0] exp_state;
   } vec_t;
   vec_t tbl[4];

   vote_capture #(
      .N_VOTERS(9), .DB_CNT(4), .TICK_CYCLES(10), .WINDOW_S(3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_raw      (sw_raw),
      .start_btn   (start_btn),
      .clear_btn   (clear_btn),
      .vote        (vote),
      .vote_valid  (vote_valid),
      .state       (state),
      .remaining_s (remaining_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every ballot that becomes final must have been predicted.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && vote_valid === 1'b1 && valid_prev !== 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: ballot %0h finalised, none expected", vote);
         end else begin
            sb_exp = exp_q.pop_front();
            chk("sb_ballot", 32'(vote), 32'(sb_exp));
         end
      end
      valid_prev = vote_valid;
   end

   // Called at a negedge; raw edge at n0, debounced pulse acts at posedge 7, returns at n16.
   task automatic press(input bit is_start);
      if (is_start) start_btn = 1'b1; else clear_btn = 1'b1;
      repeat (8) @(negedge clk);
      if (is_start) start_btn = 1'b0; else clear_btn = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_state"}, 32'(state), 32'(ENC_IDLE));
      chk({name, "_vote"}, 32'(vote), 32'h0);
      chk({name, "_valid"}, 32'(vote_valid), 32'h0);
      chk({name, "_rem"}, 32'(remaining_s), 32'h0);
   endtask

   initial begin
      int opens;
      logic [1:0] prev_st;

      tbl[0] = '{sw: 9'h155, exp_vote: 9'h155, exp_rem: 7'd1, exp_state: ENC_CLOSED};
      tbl[1] = '{sw: 9'h0AA, exp_vote: 9'h0AA, exp_rem: 7'd1, exp_state: ENC_CLOSED};
      tbl[2] = '{sw: 9'h000, exp_vote: 9'h000, exp_rem: 7'd1, exp_state: ENC_CLOSED};
      tbl[3] = '{sw: 9'h1C3, exp_vote: 9'h1C3, exp_rem: 7'd1, exp_state: ENC_CLOSED};

      rst_n = 1'b0; sw_raw = '0; start_btn = 1'b0; clear_btn = 1'b0;
      #12;
      chk_idle("reset");
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Debounce: 3-cycle glitch ignored, held level seen by vote 7 cycles after edge.
      press(1'b1);
      chk("t1_open", 32'(state), 32'(ENC_OPEN));
      sw_raw[0] = 1'b1;
      repeat (3) @(negedge clk);
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("t1_glitch", 32'(vote[0]), 32'h0);
      end
      sw_raw[0] = 1'b1;
      exp_q.push_back(9'h001);
      repeat (6) @(negedge clk);
      chk("t1_db_early", 32'(vote[0]), 32'h0);
      @(negedge clk);
      chk("t1_db_edge", 32'(vote[0]), 32'h1);
      repeat (6) @(negedge clk);
      chk("t1_timeout", 32'(state), 32'(ENC_CLOSED));
      press(1'b0);
      chk_idle("t1_clear");

      // Timed window: countdown 3,2,1,0 every 10 cycles, then closed.
      press(1'b1);
      sw_raw = 9'h1F5;
      exp_q.push_back(9'h1F5);
      for (int i = 0; i < 22; i++) begin
         chk("t2_rem", 32'(remaining_s), 32'(3 - (i + 9) / 10));
         if (i < 21) @(negedge clk);
      end
      chk("t2_state", 32'(state), 32'(ENC_CLOSED));
      chk("t2_vote", 32'(vote), 32'h1F5);
      chk("t2_valid", 32'(vote_valid), 32'h1);
      press(1'b0);
      chk_idle("t2_clear");

      // Early close and freeze.
      press(1'b1);
      sw_raw = 9'h00F;
      exp_q.push_back(9'h00F);
      repeat (8) @(negedge clk);
      press(1'b1);
      chk("t3_state", 32'(state), 32'(ENC_CLOSED));
      chk("t3_vote", 32'(vote), 32'h00F);
      chk("t3_rem", 32'(remaining_s), 32'd1);
      sw_raw = 9'h1FF;
      repeat (12) @(negedge clk);
      chk("t3_frozen", 32'(vote), 32'h00F);
      press(1'b1);
      chk("t3_restart_state", 32'(state), 32'(ENC_CLOSED));
      chk("t3_restart_vote", 32'(vote), 32'h00F);
      chk("t3_restart_rem", 32'(remaining_s), 32'd1);

      // Clear from CLOSED, then clear colliding with the timeout.
      press(1'b0);
      chk_idle("t4_clear_closed");
      press(1'b1);
      repeat (14) @(negedge clk);
      clear_btn = 1'b1;
      repeat (6) @(negedge clk);
      chk("t4_pre_state", 32'(state), 32'(ENC_OPEN));
      chk("t4_pre_rem", 32'(remaining_s), 32'd1);
      @(negedge clk);
      chk_idle("t4_clear_vs_timeout");
      @(negedge clk);
      clear_btn = 1'b0;
      repeat (10) @(negedge clk);
      chk("t4_stay_idle", 32'(state), 32'(ENC_IDLE));

      // Held start: one IDLE->OPEN, no early close from the hold.
      opens = 0;
      prev_st = state;
      start_btn = 1'b1;
      exp_q.push_back(9'h1FF);
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (prev_st == ENC_IDLE && state == ENC_OPEN) opens++;
         prev_st = state;
         if (i == 36) chk("t5_still_open", 32'(state), 32'(ENC_OPEN));
         if (i == 37) chk("t5_timeout", 32'(state), 32'(ENC_CLOSED));
      end
      chk("t5_open_count", 32'(opens), 32'd1);
      start_btn = 1'b0;
      repeat (8) @(negedge clk);
      press(1'b0);
      chk_idle("t5_clear");

      // Table of ballots closed early.
      for (int k = 0; k < 4; k++) begin
         press(1'b0);
         press(1'b1);
         sw_raw = tbl[k].sw;
         exp_q.push_back(tbl[k].exp_vote);
         repeat (8) @(negedge clk);
         press(1'b1);
         chk("tbl_state", 32'(state), 32'(tbl[k].exp_state));
         chk("tbl_vote", 32'(vote), 32'(tbl[k].exp_vote));
         chk("tbl_rem", 32'(remaining_s), 32'(tbl[k].exp_rem));
      end
      press(1'b0);

      // Async reset mid-window, between clock edges.
      press(1'b1);
      sw_raw = 9'h1AB;
      repeat (10) @(negedge clk);
      chk("t6_open", 32'(state), 32'(ENC_OPEN));
      #2 rst_n = 1'b0;
      #1;
      chk_idle("t6_async");
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_state", 32'(state), 32'(ENC_IDLE));
      chk("t6_vote", 32'(vote), 32'h0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
